// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, default baud divisor, serializer state encoding.
package mmio_uart_tx_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  localparam int unsigned STAT_BUSY      = 32'd0;
  localparam int unsigned STAT_FULL      = 32'd1;
  localparam int unsigned STAT_EMPTY     = 32'd2;
  localparam int unsigned STAT_OVF       = 32'd3;
  localparam int unsigned STAT_COUNT_LSB = 32'd8;

  localparam int unsigned UART_CLKS_PER_BIT_DEF = 32'd217;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [4:0] count);
    logic [31:0] s;
    s = 32'h0000_0000;
    s[STAT_BUSY]            = busy;
    s[STAT_FULL]            = full;
    s[STAT_EMPTY]           = empty;
    s[STAT_OVF]             = ovf;
    s[STAT_COUNT_LSB +: 5]  = count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Parameterised synchronous FIFO with first-word-fall-through read data.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32'd8,
  parameter int unsigned DEPTH = 32'd8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(32'd1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == {(AW + 1){1'b0}});
  assign full      = (count_r == CNT_FULL);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage, pointers and occupancy count
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped transmit-only 8N1 UART: DATA stores feed a byte FIFO, STATUS reports state.
// Define UART_SIM_PRINT_EN to echo every accepted byte to the simulator console.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = 32'd8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_wr_en,
  input  logic        mem_rd_en,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 32'd1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] BAUD_ZERO = CW'(32'd0);

  uart_state_e   state_r;
  uart_state_e   next_state_s;
  logic [CW-1:0] baud_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          tx_s;
  logic          ovf_r;
  logic [31:0]   rdata_r;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [AW:0]   count_s;
  logic [7:0]    head_s;
  logic          wr_data_s;
  logic          drop_s;
  logic          ovf_clr_s;
  logic          baud_zero_s;
  logic          busy_s;
  logic          unused_s;

  assign wr_data_s   = mem_wr_en && (mem_addr == REG_DATA);
  assign drop_s      = wr_data_s && full_s && !pop_s;
  assign ovf_clr_s   = mem_wr_en && (mem_addr == REG_STATUS) && mem_wdata[STAT_OVF];
  assign baud_zero_s = (baud_r == BAUD_ZERO);
  assign busy_s      = (state_r != ST_IDLE) || !empty_s;
  assign unused_s    = ^mem_wdata[31:8];
  assign tx          = tx_r;
  assign mem_rdata   = rdata_r;

  sync_fifo #(.WIDTH(32'd8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_data_s),
    .pop   (pop_s),
    .wdata (mem_wdata[7:0]),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Serializer next state, FIFO pop request and line level for the current state
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    tx_s         = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        tx_s = 1'b0;
        if (baud_zero_s) next_state_s = ST_DATA;
        else             next_state_s = ST_START;
      end
      ST_DATA: begin
        tx_s = shift_r[bit_idx_r];
        if (baud_zero_s && (bit_idx_r == 3'd7)) next_state_s = ST_STOP;
        else                                    next_state_s = ST_DATA;
      end
      ST_STOP: begin
        if (baud_zero_s) next_state_s = ST_IDLE;
        else             next_state_s = ST_STOP;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Serializer state, baud timing and registered line output
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= BAUD_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      state_r <= next_state_s;
      tx_r    <= tx_s;
      if (state_r == ST_IDLE) begin
        baud_r    <= BAUD_MAX;
        bit_idx_r <= 3'd0;
        if (pop_s) shift_r <= head_s;
      end else if (baud_zero_s) begin
        baud_r <= BAUD_MAX;
        if (state_r == ST_DATA) bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
        baud_r <= baud_r - BAUD_ONE;
      end
    end
  end

  // Sticky overflow flag and registered load data; a set beats a same-cycle clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      ovf_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      if (drop_s)         ovf_r <= 1'b1;
      else if (ovf_clr_s) ovf_r <= 1'b0;
      if (mem_rd_en) begin
        case (mem_addr)
          REG_STATUS: rdata_r <= pack_status(busy_s, full_s, empty_s, ovf_r, 5'(count_s));
          default:    rdata_r <= 32'h0000_0000;
        endcase
      end
    end
  end

`ifdef UART_SIM_PRINT_EN
  // Console mirror of accepted bytes
  always @(posedge clock) begin
    if (reset && wr_data_s && !drop_s) $write("%c", mem_wdata[7:0]);
  end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected frames and reads,
// independent monitors decode the serial line and check load data.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic        mem_rd_en = 1'b0;
  logic [3:0]  mem_addr = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        tx;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  bit          mon_busy = 1'b0;
  int          mon_cnt = 0;
  logic [7:0]  mon_byte = 8'h00;

  always #5 clock = ~clock;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx        (tx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    mem_wr_en = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick(1);
    mem_wr_en = 1'b0;
    mem_wdata = 32'h0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    mem_rd_en = 1'b1;
    mem_addr  = a;
    rd_q.push_back(e);
    rd_name_q.push_back(nm);
    tick(1);
    mem_rd_en = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s: %0d frames still pending after %0d cycles, want 0", nm, exp_q.size(), limit);
    end
  endtask

  // Serial decoder: start detected on first low sample, bits sampled mid-period
  initial forever begin
    @(negedge clock);
    if (reset !== 1'b1) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        mon_byte = 8'h00;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) chk("start_bit", {31'd0, tx}, 32'd0);
      if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
        mon_byte[(mon_cnt - 6) / 4] = tx;
      if (mon_cnt == 38) begin
        chk("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: got unexpected byte 0x%02h, want no frame", mon_byte);
        end else begin
          chk("frame", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Load-data checker: compares mem_rdata the cycle after each sampled load
  initial forever begin
    @(posedge clock);
    if (mem_rd_en === 1'b1 && reset === 1'b1) begin
      @(negedge clock);
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read: got 0x%08h, want no read pending", mem_rdata);
      end else begin
        chk(rd_name_q.pop_front(), mem_rdata, rd_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    // reset and idle
    reset = 1'b0;
    tick(3);
    chk("tx_in_reset", {31'd0, tx}, 32'd1);
    chk("rdata_in_reset", mem_rdata, 32'h0);
    reset = 1'b1;
    rd(REG_STATUS, 32'h0000_0004, "status_idle");
    chk("tx_idle", {31'd0, tx}, 32'd1);

    // single byte 0x55: start bit appears two edges after the store edge
    exp_q.push_back(8'h55);
    wr(REG_DATA, 32'h55);
    chk("tx_after_push", {31'd0, tx}, 32'd1);
    tick(1);
    chk("tx_at_pop", {31'd0, tx}, 32'd1);
    tick(1);
    chk("tx_start_latency", {31'd0, tx}, 32'd0);
    rd(REG_STATUS, 32'h0000_0005, "status_busy");
    rd(REG_DATA, 32'h0, "data_reads_zero");
    tick(40);
    rd(REG_STATUS, 32'h0000_0004, "status_done");
    rd(4'hC, 32'h0, "unmapped_reads_zero");

    // fill: 0x41 pops at once, 0x42..0x49 fill the FIFO
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(8'h41 + 8'(i));
      wr(REG_DATA, 32'h41 + 32'(i));
    end
    rd(REG_STATUS, 32'h0000_0803, "status_full");
    wr(REG_DATA, 32'h4A);
    rd(REG_STATUS, 32'h0000_080B, "status_ovf");
    wr(REG_STATUS, 32'h8);
    rd(REG_STATUS, 32'h0000_0803, "status_ovf_clr");
    // store lands on the edge where the FSM pops 0x42
    tick(28);
    exp_q.push_back(8'h4B);
    wr(REG_DATA, 32'h4B);
    rd(REG_STATUS, 32'h0000_0803, "status_push_pop_full");
    wait_drain(1000, "drain_fill");
    tick(5);
    rd(REG_STATUS, 32'h0000_0004, "status_drained");

    // reset during data bit 3 of 0xA5 with 0x3C still queued
    exp_q.push_back(8'hA5);
    wr(REG_DATA, 32'hA5);
    wr(REG_DATA, 32'h3C);
    tick(16);
    reset = 1'b0;
    exp_q.delete();
    tick(1);
    chk("tx_after_reset_edge", {31'd0, tx}, 32'd1);
    tick(1);
    reset = 1'b1;
    rd(REG_STATUS, 32'h0000_0004, "status_after_reset");
    lows = 0;
    repeat (60) begin
      tick(1);
      if (tx !== 1'b1) lows++;
    end
    chk("no_frame_after_reset", 32'(lows), 32'd0);

    // clean restart after the aborted frame
    exp_q.push_back(8'h0F);
    wr(REG_DATA, 32'h0F);
    wait_drain(200, "drain_restart");
    tick(5);
    rd(REG_STATUS, 32'h0000_0004, "status_final");
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
